// File: rtl/gvp_pkg.sv
// rtl/gvp_pkg.sv - shared types, defaults and record field offsets for gvp_ctrl
package gvp_pkg;

    localparam int VEC_W              = 512;
    localparam int DEF_NUM_VECTORS_N2 = 4;
    localparam int DEF_NUM_VECTORS    = 16;
    localparam int DEF_SETVEC_HOLD    = 8;

    // Record layout: slot address (with sign bit) at the bottom, N in the second word
    localparam int ADDR_LSB = 0;
    localparam int N_LSB    = 32;
    localparam int N_MSB    = 63;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_GAP   = 3'd2,
        ST_ARMED = 3'd3,
        ST_REARM = 3'd4,
        ST_RUN   = 3'd5,
        ST_DONE  = 3'd6
    } gvp_state_e;

endpackage

// File: rtl/gvp_ctrl_if.sv
// rtl/gvp_ctrl_if.sv - vector record stream interface for gvp_ctrl
interface gvp_ctrl_if;
    import gvp_pkg::*;

    logic [VEC_W-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/gvp_ctrl_timer.sv
// rtl/gvp_ctrl_timer.sv - hold-time down-counter shared by WRITE, GAP and REARM
module gvp_ctrl_timer #(
    parameter int HOLD = 8
) (
    input  logic a_clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    // Loading HOLD-1 makes done rise on the HOLD-th cycle after the load edge
    localparam logic [7:0] LOAD_VAL = 8'(HOLD - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Reload on state entry, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge a_clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 8'd0);

endmodule

// File: rtl/gvp_ctrl.sv
// rtl/gvp_ctrl.sv - GVP program loader / run controller; optional GVP_CTRL_WATCHDOG_EN
module gvp_ctrl
    import gvp_pkg::*;
#(
    parameter int NUM_VECTORS_N2 = DEF_NUM_VECTORS_N2,
    parameter int NUM_VECTORS    = DEF_NUM_VECTORS,
    parameter int SETVEC_HOLD    = DEF_SETVEC_HOLD
) (
    input  logic             a_clk,
    input  logic             reset,
    gvp_ctrl_if.slave        s_vec,
    input  logic             start,
    input  logic             abort,
    input  logic             pause_req,
    input  logic             gvp_finished,
    input  logic [31:0]      watchdog_limit,
    output logic             gvp_reset,
    output logic             gvp_pause,
    output logic             gvp_setvec,
    output logic [VEC_W-1:0] gvp_vp_set,
    output logic [2:0]       state,
    output logic [15:0]      run_count,
    output logic [1:0]       err
);

    localparam logic [31:0] NUM_VEC_U = NUM_VECTORS;

    gvp_state_e       state_q, state_d;
    logic [VEC_W-1:0] vp_set_q, vp_set_d;
    logic             tlast_q, tlast_d;
    logic [15:0]      run_count_q, run_count_d;
    logic [1:0]       err_q, err_d;
    logic             seen_zero_q, seen_zero_d;
    logic             setvec_q, setvec_d;
    logic             reset_q, reset_d;
    logic             pause_q, pause_d;

    logic                    tready;
    logic                    beat;
    logic [NUM_VECTORS_N2:0] addr;
    logic                    addr_ok;
    logic                    timer_load;
    logic                    timer_done;
    logic                    wd_trip;

    assign tready  = !reset && (state_q == ST_IDLE || state_q == ST_ARMED);
    assign beat    = s_vec.tvalid && tready;
    assign addr    = s_vec.tdata[ADDR_LSB +: NUM_VECTORS_N2 + 1];
    assign addr_ok = !addr[NUM_VECTORS_N2] && (32'(addr[NUM_VECTORS_N2-1:0]) < NUM_VEC_U);

    assign timer_load = (state_d != state_q) &&
                        (state_d == ST_WRITE || state_d == ST_GAP || state_d == ST_REARM);

    gvp_ctrl_timer #(.HOLD(SETVEC_HOLD)) u_timer (
        .a_clk (a_clk),
        .reset (reset),
        .load  (timer_load),
        .done  (timer_done)
    );

`ifdef GVP_CTRL_WATCHDOG_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;

    // Count cycles spent in RUN; cleared whenever RUN is left
    always_comb begin
        wd_cnt_d = (state_q == ST_RUN) ? wd_cnt_q + 32'd1 : 32'd0;
    end

    // Watchdog counter register
    always_ff @(posedge a_clk) begin
        if (reset) begin
            wd_cnt_q <= 32'd0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign wd_trip = (state_q == ST_RUN) && (watchdog_limit != 32'd0) &&
                     (wd_cnt_q >= watchdog_limit - 32'd1);
`else
    logic unused_wd_limit;
    assign unused_wd_limit = ^watchdog_limit;
    assign wd_trip         = 1'b0;
`endif

    // Next-state, latched record, counters and registered output values
    always_comb begin
        state_d     = state_q;
        vp_set_d    = vp_set_q;
        tlast_d     = tlast_q;
        run_count_d = run_count_q;
        err_d       = err_q;
        seen_zero_d = 1'b0;

        if (abort || wd_trip) begin
            state_d  = ST_IDLE;
            vp_set_d = '0;
            tlast_d  = 1'b0;
            if (wd_trip) begin
                err_d[1] = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_ARMED: begin
                    if (beat) begin
                        if (addr_ok) begin
                            state_d  = ST_WRITE;
                            vp_set_d = s_vec.tdata;
                            tlast_d  = s_vec.tlast;
                        end else begin
                            err_d[0] = 1'b1;
                        end
                    end else if (start && state_q == ST_ARMED) begin
                        state_d = ST_REARM;
                    end
                end
                ST_WRITE: if (timer_done) state_d = ST_GAP;
                ST_GAP:   if (timer_done) state_d = tlast_q ? ST_ARMED : ST_IDLE;
                ST_REARM: if (timer_done) state_d = ST_RUN;
                ST_RUN: begin
                    // finished only counts once it has been seen low since RUN entry
                    seen_zero_d = seen_zero_q || !gvp_finished;
                    if (gvp_finished && seen_zero_q) begin
                        state_d = ST_DONE;
                        if (run_count_q != 16'hFFFF) begin
                            run_count_d = run_count_q + 16'd1;
                        end
                    end
                end
                ST_DONE:  if (start) state_d = ST_REARM;
                default:  state_d = ST_IDLE;
            endcase
        end

        setvec_d = (state_d == ST_WRITE);
        reset_d  = !(state_d == ST_RUN || state_d == ST_DONE);
        pause_d  = (state_d == ST_RUN) && pause_req;
    end

    // State and output registers
    always_ff @(posedge a_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            vp_set_q    <= '0;
            tlast_q     <= 1'b0;
            run_count_q <= 16'd0;
            err_q       <= 2'b00;
            seen_zero_q <= 1'b0;
            setvec_q    <= 1'b0;
            reset_q     <= 1'b1;
            pause_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            vp_set_q    <= vp_set_d;
            tlast_q     <= tlast_d;
            run_count_q <= run_count_d;
            err_q       <= err_d;
            seen_zero_q <= seen_zero_d;
            setvec_q    <= setvec_d;
            reset_q     <= reset_d;
            pause_q     <= pause_d;
        end
    end

    assign s_vec.tready = tready;
    assign gvp_reset    = reset_q;
    assign gvp_pause    = pause_q;
    assign gvp_setvec   = setvec_q;
    assign gvp_vp_set   = vp_set_q;
    assign state        = state_q;
    assign run_count    = run_count_q;
    assign err          = err_q;

endmodule

// File: tb/tb_gvp_ctrl.sv
// tb/tb_gvp_ctrl.sv - directed self-checking bench for gvp_ctrl
module tb_gvp_ctrl;
    import gvp_pkg::*;

    logic             a_clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic             pause_req;
    logic             gvp_finished;
    logic [31:0]      watchdog_limit;
    logic             gvp_reset;
    logic             gvp_pause;
    logic             gvp_setvec;
    logic [VEC_W-1:0] gvp_vp_set;
    logic [2:0]       state;
    logic [15:0]      run_count;
    logic [1:0]       err;

    int n_tests = 0;
    int n_fail  = 0;

    gvp_ctrl_if vec_if ();

    gvp_ctrl #(
        .NUM_VECTORS_N2 (4),
        .NUM_VECTORS    (16),
        .SETVEC_HOLD    (8)
    ) dut (
        .a_clk          (a_clk),
        .reset          (reset),
        .s_vec          (vec_if.slave),
        .start          (start),
        .abort          (abort),
        .pause_req      (pause_req),
        .gvp_finished   (gvp_finished),
        .watchdog_limit (watchdog_limit),
        .gvp_reset      (gvp_reset),
        .gvp_pause      (gvp_pause),
        .gvp_setvec     (gvp_setvec),
        .gvp_vp_set     (gvp_vp_set),
        .state          (state),
        .run_count      (run_count),
        .err            (err)
    );

    initial a_clk = 1'b0;
    always #5 a_clk = ~a_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    function automatic logic [VEC_W-1:0] mk_rec(input int addr, input logic [31:0] n);
        logic [VEC_W-1:0] r;
        r = '0;
        r[31:0]          = 32'(addr);
        r[N_MSB:N_LSB]   = n;
        r[511:480]       = 32'hA5A50000 | 32'(addr);
        return r;
    endfunction

    task automatic send_beat(input int addr, input logic [31:0] n, input logic last);
        int w;
        w = 0;
        vec_if.tdata  = mk_rec(addr, n);
        vec_if.tlast  = last;
        vec_if.tvalid = 1'b1;
        while (!vec_if.tready && w < 50) begin
            tick();
            w++;
        end
        chk("beat_tready", 64'(vec_if.tready), 64'd1);
        tick();
        vec_if.tvalid = 1'b0;
        vec_if.tlast  = 1'b0;
    endtask

    // After an accepted beat: expect an 8-cycle setvec pulse, 8 low GAP cycles, stable record
    task automatic pulse_check(input string tag, input logic [VEC_W-1:0] rec, input logic [2:0] end_st);
        int hi;
        int lo;
        int bad;
        hi = 0; lo = 0; bad = 0;
        while (gvp_setvec && hi < 50) begin
            if (!gvp_reset || state != 3'd1 || gvp_vp_set !== rec) bad++;
            hi++;
            tick();
        end
        while (state == 3'd2 && lo < 50) begin
            if (!gvp_reset || gvp_setvec || gvp_vp_set !== rec) bad++;
            lo++;
            tick();
        end
        chk({tag, "_hi"}, 64'(hi), 64'd8);
        chk({tag, "_lo"}, 64'(lo), 64'd8);
        chk({tag, "_stable"}, 64'(bad), 64'd0);
        chk({tag, "_end_state"}, 64'(state), 64'(end_st));
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int bound);
        int w;
        w = 0;
        while (state != st && w < bound) begin
            tick();
            w++;
        end
        chk(tag, 64'(state), 64'(st));
    endtask

    initial begin
        int cnt;
        int bad;
        reset = 1'b1; start = 1'b0; abort = 1'b0; pause_req = 1'b0;
        gvp_finished = 1'b0; watchdog_limit = 32'd0;
        vec_if.tdata = '0; vec_if.tvalid = 1'b0; vec_if.tlast = 1'b0;

        tick();
        tick();
        chk("rst_tready", 64'(vec_if.tready), 64'd0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_gvp_reset", 64'(gvp_reset), 64'd1);
        chk("rst_setvec", 64'(gvp_setvec), 64'd0);
        chk("rst_pause", 64'(gvp_pause), 64'd0);
        chk("rst_vp_set", gvp_vp_set[63:0], 64'd0);
        chk("rst_run_count", 64'(run_count), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_tready", 64'(vec_if.tready), 64'd1);

        // Three-record program
        send_beat(0, 32'd100, 1'b0);
        pulse_check("beat0", mk_rec(0, 32'd100), 3'd0);
        send_beat(1, 32'd200, 1'b0);
        pulse_check("beat1", mk_rec(1, 32'd200), 3'd0);
        send_beat(2, 32'd300, 1'b1);
        pulse_check("beat2", mk_rec(2, 32'd300), 3'd3);
        chk("armed_gvp_reset", 64'(gvp_reset), 64'd1);

        // Negative address (sign bit set) is dropped
        send_beat(20, 32'd999, 1'b0);
        chk("bad_err", 64'(err), 64'd1);
        chk("bad_state", 64'(state), 64'd3);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (gvp_setvec) bad++;
            tick();
        end
        chk("bad_no_setvec", 64'(bad), 64'd0);
        chk("bad_vp_kept", gvp_vp_set[63:0], mk_rec(2, 32'd300)[63:0]);

        // Start with a stale finished flag
        gvp_finished = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rearm_state", 64'(state), 64'd4);
        cnt = 0;
        while (state == 3'd4 && cnt < 50) begin
            if (!gvp_reset) bad++;
            cnt++;
            tick();
        end
        chk("rearm_cycles", 64'(cnt), 64'd8);
        chk("run_state", 64'(state), 64'd5);
        chk("run_gvp_reset", 64'(gvp_reset), 64'd0);
        chk("pause_idle", 64'(gvp_pause), 64'd0);
        pause_req = 1'b1;
        tick();
        chk("pause_on", 64'(gvp_pause), 64'd1);
        chk("stale1_state", 64'(state), 64'd5);
        pause_req = 1'b0;
        tick();
        chk("pause_off", 64'(gvp_pause), 64'd0);
        chk("stale2_state", 64'(state), 64'd5);
        tick();
        chk("stale3_state", 64'(state), 64'd5);
        gvp_finished = 1'b0;
        tick();
        chk("low_state", 64'(state), 64'd5);
        gvp_finished = 1'b1;
        tick();
        gvp_finished = 1'b0;
        chk("done_state", 64'(state), 64'd6);
        chk("done_run_count", 64'(run_count), 64'd1);
        chk("done_gvp_reset", 64'(gvp_reset), 64'd0);

        // No beat accepted in DONE
        chk("done_tready", 64'(vec_if.tready), 64'd0);
        vec_if.tdata  = mk_rec(5, 32'd55);
        vec_if.tvalid = 1'b1;
        tick();
        vec_if.tvalid = 1'b0;
        chk("done_beat_state", 64'(state), 64'd6);
        chk("done_beat_vp", gvp_vp_set[63:0], mk_rec(2, 32'd300)[63:0]);

        // abort wins over start
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_state", 64'(state), 64'd0);
        chk("abort_gvp_reset", 64'(gvp_reset), 64'd1);
        chk("abort_run_count", 64'(run_count), 64'd1);
        chk("abort_vp_drop", gvp_vp_set[63:0], 64'd0);

        // Reset in the middle of WRITE
        vec_if.tdata  = mk_rec(3, 32'd33);
        send_beat(3, 32'd33, 1'b1);
        tick();
        tick();
        chk("midwrite_setvec", 64'(gvp_setvec), 64'd1);
        reset = 1'b1;
        tick();
        chk("midrst_setvec", 64'(gvp_setvec), 64'd0);
        chk("midrst_state", 64'(state), 64'd0);
        chk("midrst_err", 64'(err), 64'd0);
        chk("midrst_run_count", 64'(run_count), 64'd0);
        reset = 1'b0;
        tick();

        // Watchdog
        watchdog_limit = 32'd100;
        send_beat(4, 32'd44, 1'b1);
        wait_state("wd_armed", 3'd3, 60);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_state("wd_run", 3'd5, 20);
        cnt = 0;
`ifdef GVP_CTRL_WATCHDOG_EN
        while (state == 3'd5 && cnt < 300) begin
            cnt++;
            tick();
        end
        chk("wd_run_cycles", 64'(cnt), 64'd100);
        chk("wd_state", 64'(state), 64'd0);
        chk("wd_err", 64'(err), 64'd2);
        chk("wd_gvp_reset", 64'(gvp_reset), 64'd1);
`else
        while (state == 3'd5 && cnt < 150) begin
            cnt++;
            tick();
        end
        chk("nowd_run_cycles", 64'(cnt), 64'd150);
        chk("nowd_err", 64'(err), 64'd0);
        gvp_finished = 1'b1;
        tick();
        gvp_finished = 1'b0;
        chk("nowd_done", 64'(state), 64'd6);
        chk("nowd_run_count", 64'(run_count), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gvp_ctrl.md
GVP_CTRL -- requirements
Module: gvp_ctrl

Interface
REQ-001 SHALL have parameter NUM_VECTORS_N2, default 4, vector address width minus sign bit.
REQ-002 SHALL have parameter NUM_VECTORS, default 16, number of program slots.
REQ-003 SHALL have parameter SETVEC_HOLD, default 8, a_clk cycles that setvec, gap and re-arm reset are held (range 1..255).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 a_clk  in  1  sole clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 s_vec_tdata  in  512  vector record; address in [NUM_VECTORS_N2:0], N in [63:32].
REQ-008 s_vec_tvalid / s_vec_tready / s_vec_tlast  in/out/in  1 each  record handshake; tlast marks final record of a program.
REQ-009 start, abort, pause_req  in  1 each  host commands, level-sampled each cycle.
REQ-010 gvp_finished  in  1  finished flag from the GVP core.
REQ-011 watchdog_limit  in  32  maximum RUN duration in a_clk cycles; 0 disables the watchdog.
REQ-012 gvp_reset, gvp_pause, gvp_setvec  out  1 each  GVP control lines.
REQ-013 gvp_vp_set  out  512  record presented to the GVP.
REQ-014 state  out  3  current FSM state code; run_count  out  16  completed runs; err  out  2  sticky {watchdog, bad_addr}.

Function
REQ-015 FSM states SHALL be IDLE=0, WRITE=1, GAP=2, ARMED=3, REARM=4, RUN=5, DONE=6.
REQ-016 s_vec_tready SHALL be 1 only in IDLE and ARMED; a beat is accepted on tvalid&tready.
REQ-017 An accepted beat with address >= NUM_VECTORS or negative SHALL be dropped, SHALL set err[0], and SHALL leave the state unchanged.
REQ-018 An accepted valid beat SHALL latch tdata and tlast into gvp_vp_set on the next edge, clear the armed status, and enter WRITE.
REQ-019 WRITE SHALL drive gvp_setvec=1 for exactly SETVEC_HOLD cycles, then enter GAP.
REQ-020 GAP SHALL drive gvp_setvec=0 for exactly SETVEC_HOLD cycles, then enter ARMED if the latched tlast=1 and IDLE otherwise.
REQ-021 gvp_vp_set SHALL stay stable from WRITE entry until GAP exit.
REQ-022 gvp_reset SHALL be 1 in all states except RUN and DONE.
REQ-023 start in ARMED or DONE SHALL enter REARM; start in any other state SHALL be ignored.
REQ-024 REARM SHALL hold gvp_reset=1 for SETVEC_HOLD cycles, then enter RUN.
REQ-025 In RUN, gvp_pause SHALL equal pause_req delayed by one cycle; it SHALL be 0 in every other state.
REQ-026 In RUN, gvp_finished SHALL be qualified only after it has been sampled 0 at least once since RUN entry, which blanks the stale flag.
REQ-027 A qualified gvp_finished=1 SHALL enter DONE and increment run_count, saturating at 16'hFFFF.
REQ-028 DONE SHALL keep gvp_reset=0 so the GVP holds its final outputs.
REQ-029 A vector beat in DONE SHALL NOT be accepted.
REQ-030 abort SHALL force IDLE from any state on the next edge, drop any latched beat, and drive gvp_setvec=0.
REQ-031 abort SHALL take priority over start and over a simultaneous beat or finished.
REQ-032 All outputs SHALL be registered, with one-cycle latency from the state change.

Reset
REQ-033 On reset the block SHALL enter IDLE with gvp_reset=1 and gvp_setvec=0, gvp_pause=0, gvp_vp_set=0, run_count=0, err=0.
REQ-034 s_vec_tready SHALL be 0 during any cycle with reset asserted.
REQ-035 Reset mid-WRITE SHALL deassert gvp_setvec on the next edge.

Configuration
REQ-036 With GVP_CTRL_WATCHDOG_EN defined, a RUN cycle counter SHALL run; when it reaches a nonzero watchdog_limit the block SHALL set err[1] and behave as abort.
REQ-037 Without GVP_CTRL_WATCHDOG_EN, watchdog_limit SHALL be ignored, err[1] SHALL be constant 0, and no counter SHALL be synthesized.

Structure
REQ-038 Package gvp_pkg SHALL hold the state enum, NUM_VECTORS defaults, and the record field offsets (address, N).
REQ-039 Sub-module gvp_ctrl_timer SHALL provide the shared SETVEC_HOLD down-counter (load, done) used by WRITE, GAP and REARM.

Verification
REQ-040 Three beats at addresses 0, 1, 2, tlast on the third, SETVEC_HOLD=8 -> three setvec pulses of 8 cycles, each followed by 8 low cycles; state=ARMED; gvp_reset=1 throughout.
REQ-041 Beat at address 20 -> err=2'b01, no setvec pulse, state unchanged.
REQ-042 start in ARMED, gvp_finished stale 1 for 3 cycles, then 0, then 1 -> RUN entered after 8 REARM cycles, stale flag ignored, DONE on the real flag, run_count=1.
REQ-043 pause_req=1 during RUN -> gvp_pause=1 one cycle later; pause_req=0 -> gvp_pause returns to 0.
REQ-044 abort and start asserted in the same cycle in DONE -> IDLE, gvp_reset=1, run_count unchanged.
REQ-045 With GVP_CTRL_WATCHDOG_EN, watchdog_limit=100 and no finished -> IDLE after 100 RUN cycles, err=2'b10.
